game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_game_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game mode controller: INITIAL/PLAY/LEARN/DEAD state machine, learning episode
// counter and per-frame learning event reporting from the obstacle channels.
module game_ctrl #(
  parameter int unsigned NUM_OBST       = 2,
  parameter int unsigned POS_W          = 10,
  parameter int unsigned WIN_LO         = 620,
  parameter int unsigned WIN_HI         = 626,
  parameter int unsigned RESTART_FRAMES = 30,
  parameter int unsigned EPI_W          = 16,
  localparam int unsigned IDX_W         = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      new_frame,
  input  logic                      jump,
  input  logic                      q_key,
  input  logic                      jumping,
  input  logic [NUM_OBST-1:0]       hit_vec,
  input  logic [NUM_OBST-1:0]       obst_valid,
  input  logic [NUM_OBST*POS_W-1:0] obst_pos,
  output logic [1:0]                state,
  output logic [1:0]                qstate,
  output logic [IDX_W-1:0]          qstate_idx,
  output logic [EPI_W-1:0]          episode_cnt,
  output logic                      learn_mode
);

  localparam int unsigned CNT_W = (RESTART_FRAMES > 1) ? $clog2(RESTART_FRAMES + 1) : 1;

  localparam logic [1:0] S_INITIAL = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_LEARN   = 2'd2;
  localparam logic [1:0] S_DEAD    = 2'd3;

  localparam logic [POS_W-1:0] WIN_LO_P  = POS_W'(WIN_LO);
  localparam logic [POS_W-1:0] WIN_HI_P  = POS_W'(WIN_HI);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RESTART_FRAMES - 1);
  localparam logic [EPI_W-1:0] EPI_MAX   = {EPI_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             learn_q, learn_d;
  logic             jump_q, q_key_q;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [EPI_W-1:0] episode_q, episode_d;
  logic [1:0]       acc_code_q, acc_code_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [1:0]       qstate_q, qstate_d;
  logic [IDX_W-1:0] qidx_q, qidx_d;

  logic             jump_rise, q_rise, hit;
  logic [1:0]       ev_code, ch_code;
  logic [IDX_W-1:0] ev_idx;
  logic [POS_W-1:0] ch_pos;

  assign jump_rise = jump & ~jump_q;
  assign q_rise    = q_key & ~q_key_q;
  assign hit       = |(hit_vec & obst_valid);

  // Cycle event: numerically largest code wins, strict compare keeps lowest index on ties
  always_comb begin
    ev_code = 2'b00;
    ev_idx  = '0;
    ch_code = 2'b00;
    ch_pos  = '0;
    if (state_q == S_LEARN) begin
      for (int i = 0; i < NUM_OBST; i++) begin
        ch_pos  = obst_pos[i*POS_W +: POS_W];
        ch_code = 2'b00;
        if (hit_vec[i] && obst_valid[i]) begin
          ch_code = jumping ? 2'b11 : 2'b10;
        end else if (obst_valid[i] && (ch_pos >= WIN_LO_P) && (ch_pos < WIN_HI_P)) begin
          ch_code = 2'b01;
        end
        if (ch_code > ev_code) begin
          ev_code = ch_code;
          ev_idx  = IDX_W'(i);
        end
      end
    end
  end

  // Frame accumulator and per-frame report
  always_comb begin
    acc_code_d = acc_code_q;
    acc_idx_d  = acc_idx_q;
    qstate_d   = 2'b00;
    qidx_d     = qidx_q;
    if (new_frame) begin
      qstate_d   = acc_code_q;
      qidx_d     = acc_idx_q;
      acc_code_d = ev_code;
      acc_idx_d  = ev_idx;
    end else if (ev_code > acc_code_q) begin
      acc_code_d = ev_code;
      acc_idx_d  = ev_idx;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    learn_d   = learn_q;
    rcnt_d    = rcnt_q;
    episode_d = episode_q;
    case (state_q)
      S_INITIAL: begin
        if (jump_rise) begin
          state_d = S_PLAY;
          learn_d = 1'b0;
        end else if (q_rise || learn_q) begin
          state_d = S_LEARN;
          learn_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (hit) begin
          state_d = S_DEAD;
          rcnt_d  = '0;
        end
      end
      S_LEARN: begin
        if (q_rise) begin
          state_d = S_INITIAL;
          learn_d = 1'b0;
        end else if (hit) begin
          state_d = S_DEAD;
          rcnt_d  = '0;
          if (episode_q != EPI_MAX) begin
            episode_d = episode_q + EPI_W'(1);
          end
        end
      end
      default: begin
        if (!learn_q) begin
          if (jump_rise) begin
            state_d = S_INITIAL;
          end
        end else if (new_frame) begin
          if (rcnt_q == CNT_LAST) begin
            state_d = S_INITIAL;
          end else begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INITIAL;
      learn_q    <= 1'b0;
      jump_q     <= 1'b0;
      q_key_q    <= 1'b0;
      rcnt_q     <= '0;
      episode_q  <= '0;
      acc_code_q <= 2'b00;
      acc_idx_q  <= '0;
      qstate_q   <= 2'b00;
      qidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      learn_q    <= learn_d;
      jump_q     <= jump;
      q_key_q    <= q_key;
      rcnt_q     <= rcnt_d;
      episode_q  <= episode_d;
      acc_code_q <= acc_code_d;
      acc_idx_q  <= acc_idx_d;
      qstate_q   <= qstate_d;
      qidx_q     <= qidx_d;
    end
  end

  assign state       = state_q;
  assign learn_mode  = learn_q;
  assign episode_cnt = episode_q;
  assign qstate      = qstate_q;
  assign qstate_idx  = qidx_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios followed by random stimulus, all
// compared every cycle against a rule-level reference model.
module tb_game_ctrl;

  localparam int NUM_OBST = 2;
  localparam int POS_W    = 10;
  localparam int RESTART  = 30;
  localparam int EPI_MAX  = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_frame, jump, q_key, jumping;
  logic [1:0]  hit_vec, obst_valid;
  logic [19:0] obst_pos;
  logic [1:0]  state, qstate;
  logic [0:0]  qstate_idx;
  logic [15:0] episode_cnt;
  logic        learn_mode;

  int checks   = 0;
  int failures = 0;

  // Reference model: state names as ints 0..3, counter counts pulses seen in DEAD
  int m_state, m_learn, m_epi, m_pulses, m_acc_c, m_acc_i, m_qs, m_qi, m_pj, m_pq;

  game_ctrl #(
    .NUM_OBST(2), .POS_W(10), .WIN_LO(620), .WIN_HI(626),
    .RESTART_FRAMES(30), .EPI_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .new_frame(new_frame), .jump(jump), .q_key(q_key),
    .jumping(jumping), .hit_vec(hit_vec), .obst_valid(obst_valid), .obst_pos(obst_pos),
    .state(state), .qstate(qstate), .qstate_idx(qstate_idx),
    .episode_cnt(episode_cnt), .learn_mode(learn_mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout state=%0d", state);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_learn = 0; m_epi = 0; m_pulses = 0;
    m_acc_c = 0; m_acc_i = 0; m_qs = 0; m_qi = 0; m_pj = 0; m_pq = 0;
  endfunction

  function automatic int chan_code(int i);
    int p;
    p = int'(obst_pos[i*POS_W +: POS_W]);
    if (hit_vec[i] && obst_valid[i]) return jumping ? 3 : 2;
    if (obst_valid[i] && p >= 620 && p < 626) return 1;
    return 0;
  endfunction

  function automatic void model_step();
    int jr, qr, hit, ev_c, ev_i, nxt;
    jr  = (jump && !m_pj) ? 1 : 0;
    qr  = (q_key && !m_pq) ? 1 : 0;
    hit = ((hit_vec & obst_valid) != 0) ? 1 : 0;
    ev_c = 0; ev_i = 0;
    if (m_state == 2) begin
      for (int p = 3; p >= 1; p--)
        for (int i = 0; i < NUM_OBST; i++)
          if (ev_c == 0 && chan_code(i) == p) begin ev_c = p; ev_i = i; end
    end
    if (new_frame) begin
      m_qs = m_acc_c; m_qi = m_acc_i; m_acc_c = ev_c; m_acc_i = ev_i;
    end else begin
      m_qs = 0;
      if (ev_c > m_acc_c) begin m_acc_c = ev_c; m_acc_i = ev_i; end
    end
    nxt = m_state;
    case (m_state)
      0: if (jr != 0) begin nxt = 1; m_learn = 0; end
         else if (qr != 0 || m_learn != 0) begin nxt = 2; m_learn = 1; end
      1: if (hit != 0) nxt = 3;
      2: if (qr != 0) begin nxt = 0; m_learn = 0; end
         else if (hit != 0) begin nxt = 3; if (m_epi < EPI_MAX) m_epi++; end
      default:
        if (m_learn == 0) begin
          if (jr != 0) nxt = 0;
        end else if (new_frame) begin
          m_pulses++;
          if (m_pulses == RESTART) nxt = 0;
        end
    endcase
    if (nxt == 3 && m_state != 3) m_pulses = 0;
    m_state = nxt;
    m_pj = jump ? 1 : 0;
    m_pq = q_key ? 1 : 0;
  endfunction

  task automatic check_all(input string where);
    check({where, ".state"},   state,       m_state);
    check({where, ".learn"},   learn_mode,  m_learn);
    check({where, ".episode"}, episode_cnt, m_epi);
    check({where, ".qstate"},  qstate,      m_qs);
    check({where, ".qidx"},    qstate_idx,  m_qi);
  endtask

  task automatic tick(input string where);
    @(posedge clk);
    model_step();
    #1;
    check_all(where);
  endtask

  task automatic clear_obst();
    hit_vec = 2'b00; obst_valid = 2'b00; obst_pos = '0; jumping = 1'b0;
  endtask

  // Pulse frames until the learning-mode restart leaves DEAD; returns pulses seen
  task automatic frames_until_restart(output int pulses);
    pulses = 0;
    while (pulses < 40) begin
      new_frame = 1'b1;
      tick("restart");
      new_frame = 1'b0;
      pulses++;
      if (state !== 2'd3) break;
      tick("restart_gap");
    end
  endtask

  int pulses, epi_before;
  int pos_tab[4] = '{619, 620, 625, 626};
  int exp_tab[4] = '{0, 1, 1, 0};

  initial begin
    rst_n = 1'b0; new_frame = 1'b0; jump = 1'b0; q_key = 1'b0;
    clear_obst();
    model_reset();
    #3;
    check_all("reset");
    #9 rst_n = 1'b1;
    #1;
    check("post_release_state", state, 0);
    tick("idle");

    // Held jump must not restart from DEAD; a fresh press does
    jump = 1'b1;
    tick("to_play");
    check("play_state", state, 1);
    hit_vec = 2'b01; obst_valid = 2'b01;
    tick("play_hit");
    check("dead_state", state, 3);
    clear_obst();
    for (int k = 0; k < 3; k++) tick("dead_held");
    check("dead_held_state", state, 3);
    jump = 1'b0;
    tick("jump_release");
    jump = 1'b1;
    tick("jump_press");
    check("restart_state", state, 0);
    jump = 1'b0;
    tick("after_restart");

    // Learn, die on a non-jumping hit, then auto-restart
    q_key = 1'b1;
    tick("to_learn");
    check("learn_state", state, 2);
    q_key = 1'b0;
    tick("learn_idle");
    hit_vec = 2'b01; obst_valid = 2'b01;
    tick("learn_hit");
    check("learn_dead_episode", episode_cnt, 1);
    clear_obst();
    tick("dead_wait");
    new_frame = 1'b1;
    tick("fatal_frame");
    check("fatal_qstate", qstate, 2);
    check("fatal_qidx", qstate_idx, 0);
    new_frame = 1'b0;
    tick("fatal_after");
    check("qstate_one_cycle", qstate, 0);
    frames_until_restart(pulses);
    check("restart_pulses", pulses + 1, 30);
    check("auto_restart_state", state, 0);
    tick("relearn");
    check("relearn_state", state, 2);

    // Window event first, then a jumping hit on ch1 supersedes it
    obst_valid = 2'b01; obst_pos[9:0] = 10'd622;
    tick("ch0_window");
    obst_valid = 2'b11; obst_pos[19:10] = 10'd100; hit_vec = 2'b10; jumping = 1'b1;
    tick("ch1_hit");
    clear_obst();
    new_frame = 1'b1;
    tick("mix_frame");
    check("mix_qstate", qstate, 3);
    check("mix_qidx", qstate_idx, 1);
    new_frame = 1'b0;
    frames_until_restart(pulses);
    tick("relearn2");
    check("relearn2_state", state, 2);
    new_frame = 1'b1;
    tick("flush_frame");
    new_frame = 1'b0;
    tick("flush_gap");

    // Event coincident with new_frame is reported one frame later
    obst_valid = 2'b01; obst_pos[9:0] = 10'd620; new_frame = 1'b1;
    tick("coinc_frame");
    check("coinc_qstate", qstate, 0);
    clear_obst(); new_frame = 1'b0;
    tick("coinc_gap");
    new_frame = 1'b1;
    tick("coinc_next");
    check("coinc_next_qstate", qstate, 1);
    new_frame = 1'b0;

    // Window boundaries
    for (int k = 0; k < 4; k++) begin
      obst_valid = 2'b01; obst_pos[9:0] = 10'(pos_tab[k]);
      tick("win_set");
      clear_obst(); new_frame = 1'b1;
      tick("win_frame");
      check($sformatf("win_pos%0d", pos_tab[k]), qstate, exp_tab[k]);
      new_frame = 1'b0;
      tick("win_gap");
    end

    // q_rise beats hit in LEARN
    epi_before = int'(episode_cnt);
    hit_vec = 2'b01; obst_valid = 2'b01; q_key = 1'b1;
    tick("q_vs_hit");
    check("q_vs_hit_state", state, 0);
    check("q_vs_hit_learn", learn_mode, 0);
    check("q_vs_hit_episode", episode_cnt, epi_before);
    clear_obst(); q_key = 1'b0;
    tick("q_vs_hit_after");
    check("stay_initial", state, 0);

    // Asynchronous reset mid-cycle with a pending event
    q_key = 1'b1;
    tick("to_learn3");
    q_key = 1'b0;
    obst_valid = 2'b01; obst_pos[9:0] = 10'd621;
    tick("pending");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_state", state, 0);
    check("async_learn", learn_mode, 0);
    check("async_episode", episode_cnt, 0);
    check("async_qstate", qstate, 0);
    clear_obst();
    #3 rst_n = 1'b1;
    new_frame = 1'b1;
    tick("post_reset_frame");
    check("post_reset_qstate", qstate, 0);
    new_frame = 1'b0;

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) jump = ~jump;
      if ($urandom_range(39) == 0) q_key = ~q_key;
      new_frame  = ($urandom_range(4) == 0);
      obst_valid = 2'($urandom);
      hit_vec    = ($urandom_range(11) == 0) ? 2'($urandom) : 2'b00;
      jumping    = 1'($urandom);
      obst_pos[9:0]   = 10'(615 + $urandom_range(14));
      obst_pos[19:10] = 10'(615 + $urandom_range(14));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
